ir_fetch_sequencer: RTL and testbench

//   Multi-cycle fetch/decode controller in front of the instruction register.

---
 rtl/ir_fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_ir_fetch_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// ir_fetch_sequencer
//   Multi-cycle fetch/decode controller in front of the instruction register.
//   Holds the PC, fetches a 16-bit word over a req/ack handshake, presents it
//   to the IR with a one-cycle load strobe, launches the execute datapath and
//   waits for it to finish. Supports branch redirect, a HALT opcode and an
//   external pause request sampled at instruction completion.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           level: leave IDLE/HALT and begin fetching
//   halt_req        level: pause (go IDLE) when the current instruction ends
//   imem_req/addr   fetch request and address (address = pc)
//   imem_ack/rdata  fetch completion and instruction word
//   ir_din          word presented to the IR (holds last fetched word)
//   ir_write_en     IR load strobe, one cycle, driven straight from a flop
//   opcode          opcode of the held instruction
//   exec_start      one-cycle execute launch pulse
//   exec_done       execute finished; branch_taken/branch_target sampled here
//   pc              program counter
//   busy, halted    status flags
// ---------------------------------------------------------------------------
module ir_fetch_sequencer #(
   parameter int unsigned        PC_W     = 8,
   parameter logic [PC_W-1:0]    RESET_PC = '0,
   parameter logic [3:0]         HALT_OP  = 4'hF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            halt_req,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   output logic [15:0]     ir_din,
   output logic            ir_write_en,
   output logic [3:0]      opcode,
   output logic            exec_start,
   input  logic            exec_done,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   output logic [PC_W-1:0] pc,
   output logic            busy,
   output logic            halted
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_EXEC  = 3'd3,
      S_WAIT  = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       instr_q, instr_d;
   logic [3:0]        opcode_q, opcode_d;

   // Every output strobe/flag is its own flop, loaded from the next-state
   // decode, so nothing downstream ever sees decode glitches (the IR is
   // edge-sensitive on ir_write_en).
   logic              req_q, we_q, xs_q, busy_q, halted_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      opcode_d = opcode_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            // Word and opcode captured together so both are valid for the
            // whole LOAD cycle while the strobe is high.
            if (imem_ack) begin
               instr_d  = imem_rdata;
               opcode_d = imem_rdata[15:12];
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = (instr_q[15:12] == HALT_OP) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // halt_req only matters here, so a pause never aborts an
            // instruction in flight.
            if (exec_done) begin
               pc_d    = branch_taken ? branch_target : pc_q + 1'b1;
               state_d = halt_req ? S_IDLE : S_FETCH;
            end
         end
         S_HALT: begin
            if (start) begin
               pc_d    = RESET_PC;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= '0;
         opcode_q <= '0;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         xs_q     <= 1'b0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         opcode_q <= opcode_d;
         req_q    <= (state_d == S_FETCH);
         we_q     <= (state_d == S_LOAD);
         xs_q     <= (state_d == S_EXEC);
         busy_q   <= (state_d == S_FETCH) || (state_d == S_LOAD) ||
                     (state_d == S_EXEC)  || (state_d == S_WAIT);
         halted_q <= (state_d == S_HALT);
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign ir_din      = instr_q;
   assign ir_write_en = we_q;
   assign opcode      = opcode_q;
   assign exec_start  = xs_q;
   assign pc          = pc_q;
   assign busy        = busy_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
module tb_ir_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        halt_req = 1'b0;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic [15:0] ir_din;
   logic        ir_write_en;
   logic [3:0]  opcode;
   logic        exec_start;
   logic        exec_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = '0;
   logic [7:0]  pc;
   logic        busy;
   logic        halted;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int xs_cnt = 0;

   ir_fetch_sequencer #(.PC_W(8), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .ir_din(ir_din), .ir_write_en(ir_write_en),
      .opcode(opcode), .exec_start(exec_start), .exec_done(exec_done),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .pc(pc), .busy(busy), .halted(halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ir_write_en) we_cnt <= we_cnt + 1;
      if (exec_start)  xs_cnt <= xs_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 0; halt_req = 0; imem_ack = 0; exec_done = 0;
      branch_taken = 0; branch_target = '0; imem_rdata = '0;
      step(); step();
      rst = 1'b0;
   endtask

   // Drives one non-HALT instruction with immediate ack/done; starts and ends in FETCH.
   task automatic do_instr(input logic [15:0] word, input logic br, input logic [7:0] tgt);
      imem_ack = 1; imem_rdata = word; step();
      imem_ack = 0; step(); step();
      exec_done = 1; branch_taken = br; branch_target = tgt; step();
      exec_done = 0; branch_taken = 0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req === 1'b1) begin ok = 1; break; end
         step();
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({imem_req, ir_write_en, exec_start, busy, halted} !== 5'b0 ||
             pc !== 8'h00 || ir_din !== 16'h0 || opcode !== 4'h0)
            begin errors++; $display("FAIL reset_idle: req=%b we=%b xs=%b busy=%b halted=%b pc=%h ir=%h op=%h required all zero",
                            imem_req, ir_write_en, exec_start, busy, halted, pc, ir_din, opcode); end
         step();
      end
   endtask

   task automatic test_reset_mid_wait();
      start = 1; step(); start = 0;
      do_instr(16'h2000, 1'b1, 8'h5A);
      imem_ack = 1; imem_rdata = 16'h3333; step();
      imem_ack = 0; step(); step();
      checks++;
      if (busy !== 1'b1 || pc !== 8'h5A)
         begin errors++; $display("FAIL pre_reset_wait: busy=%b pc=%h required busy=1 pc=5a", busy, pc); end
      #3 rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({imem_req, ir_write_en, exec_start, busy, halted} !== 5'b0 || pc !== 8'h00 ||
          ir_din !== 16'h0 || opcode !== 4'h0)
         begin errors++; $display("FAIL reset_mid_wait: req=%b we=%b xs=%b busy=%b halted=%b pc=%h ir=%h op=%h required zero",
                         imem_req, ir_write_en, exec_start, busy, halted, pc, ir_din, opcode); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_single();
      int we0;
      do_reset();
      we0 = we_cnt;
      start = 1; step(); start = 0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00)
         begin errors++; $display("FAIL single_fetch: req=%b addr=%h required 1/00", imem_req, imem_addr); end
      imem_ack = 1; imem_rdata = 16'h1234; step(); imem_ack = 0; imem_rdata = 16'hDEAD;
      checks++;
      if (ir_write_en !== 1'b1 || ir_din !== 16'h1234 || opcode !== 4'h1)
         begin errors++; $display("FAIL single_load: we=%b ir=%h op=%h required 1/1234/1", ir_write_en, ir_din, opcode); end
      step();
      checks++;
      if (ir_write_en !== 1'b0 || exec_start !== 1'b1 || ir_din !== 16'h1234)
         begin errors++; $display("FAIL single_exec: we=%b xs=%b ir=%h required 0/1/1234", ir_write_en, exec_start, ir_din); end
      step();
      checks++;
      if (exec_start !== 1'b0 || busy !== 1'b1)
         begin errors++; $display("FAIL single_wait: xs=%b busy=%b required 0/1", exec_start, busy); end
      exec_done = 1; step(); exec_done = 0;
      checks++;
      if (pc !== 8'h01 || imem_req !== 1'b1 || imem_addr !== 8'h01 || (we_cnt - we0) !== 1)
         begin errors++; $display("FAIL single_next: pc=%h req=%b addr=%h strobes=%0d required 01/1/01/1",
                         pc, imem_req, imem_addr, we_cnt - we0); end
   endtask

   task automatic test_ack_delay();
      int we0;
      we0 = we_cnt;
      imem_rdata = 16'hBEEF;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 8'h01 || ir_write_en !== 1'b0)
            begin errors++; $display("FAIL ack_delay_hold[%0d]: req=%b addr=%h we=%b required 1/01/0",
                            i, imem_req, imem_addr, ir_write_en); end
         if (i < 5) step();
      end
      imem_ack = 1; imem_rdata = 16'h7ABC; step(); imem_ack = 0;
      checks++;
      if (ir_write_en !== 1'b1 || ir_din !== 16'h7ABC || (we_cnt - we0) !== 0)
         begin errors++; $display("FAIL ack_delay_load: we=%b ir=%h prior=%0d required 1/7abc/0", ir_write_en, ir_din, we_cnt - we0); end
      step();
      checks++;
      if (ir_write_en !== 1'b0 || (we_cnt - we0) !== 1)
         begin errors++; $display("FAIL ack_delay_pulse: we=%b strobes=%0d required 0/1", ir_write_en, we_cnt - we0); end
      step();
      exec_done = 1; step(); exec_done = 0;
   endtask

   task automatic test_branch_wrap();
      imem_ack = 1; imem_rdata = 16'h4000; step(); imem_ack = 0; step(); step();
      exec_done = 1; branch_taken = 1; branch_target = 8'h40; step();
      exec_done = 0; branch_taken = 0;
      checks++;
      if (imem_addr !== 8'h40 || pc !== 8'h40 || imem_req !== 1'b1)
         begin errors++; $display("FAIL branch_target: addr=%h pc=%h req=%b required 40/40/1", imem_addr, pc, imem_req); end
      do_instr(16'h1111, 1'b1, 8'hFF);
      checks++;
      if (pc !== 8'hFF)
         begin errors++; $display("FAIL branch_ff: pc=%h required ff", pc); end
      do_instr(16'h2222, 1'b0, 8'h33);
      checks++;
      if (pc !== 8'h00 || imem_addr !== 8'h00)
         begin errors++; $display("FAIL pc_wrap: pc=%h addr=%h required 00/00", pc, imem_addr); end
   endtask

   task automatic test_halt();
      int xs0;
      do_instr(16'h5000, 1'b1, 8'h37);
      xs0 = xs_cnt;
      imem_ack = 1; imem_rdata = 16'hF000; step(); imem_ack = 0;
      checks++;
      if (ir_write_en !== 1'b1 || opcode !== 4'hF || ir_din !== 16'hF000)
         begin errors++; $display("FAIL halt_load: we=%b op=%h ir=%h required 1/f/f000", ir_write_en, opcode, ir_din); end
      halt_req = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (halted !== 1'b1 || busy !== 1'b0 || exec_start !== 1'b0 || imem_req !== 1'b0 ||
             pc !== 8'h37 || xs_cnt != xs0)
            begin errors++; $display("FAIL halt_state[%0d]: halted=%b busy=%b xs=%b req=%b pc=%h launches=%0d required 1/0/0/0/37/0",
                            i, halted, busy, exec_start, imem_req, pc, xs_cnt - xs0); end
      end
      halt_req = 0;
      start = 1; step(); start = 0;
      checks++;
      if (halted !== 1'b0 || imem_req !== 1'b1 || pc !== 8'h00 || imem_addr !== 8'h00)
         begin errors++; $display("FAIL halt_restart: halted=%b req=%b pc=%h addr=%h required 0/1/00/00",
                         halted, imem_req, pc, imem_addr); end
   endtask

   task automatic test_halt_req();
      halt_req = 1;
      imem_ack = 1; imem_rdata = 16'h2222; step(); imem_ack = 0; step(); step();
      checks++;
      if (busy !== 1'b1)
         begin errors++; $display("FAIL haltreq_no_abort: busy=%b required 1", busy); end
      exec_done = 1; step(); exec_done = 0; halt_req = 0;
      checks++;
      if (pc !== 8'h01 || busy !== 1'b0 || imem_req !== 1'b0 || halted !== 1'b0)
         begin errors++; $display("FAIL haltreq_idle: pc=%h busy=%b req=%b halted=%b required 01/0/0/0", pc, busy, imem_req, halted); end
      step(); step();
      checks++;
      if (imem_req !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL haltreq_stay: req=%b busy=%b required 0/0", imem_req, busy); end
      start = 1; step(); start = 0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h01)
         begin errors++; $display("FAIL haltreq_resume: req=%b addr=%h required 1/01", imem_req, imem_addr); end
   endtask

   // Randomized run against an instruction-level model: each instruction is
   // fetched at pc_m, loaded once, then pc_m moves to target or pc_m+1 (mod
   // 256); HALT opcodes freeze pc_m until restart at 0, pauses resume at pc_m.
   task automatic test_random();
      logic [7:0]  pc_m, tgt;
      logic [15:0] word;
      logic [3:0]  op;
      logic        br, hr;
      bit          ok;
      int          dly, xs0;
      do_reset();
      pc_m = 8'h00;
      start = 1; step(); start = 0;
      for (int k = 0; k < 80; k++) begin
         wait_req(ok);
         checks++;
         if (!ok || imem_addr !== pc_m)
            begin errors++; $display("FAIL rand_fetch[%0d]: req_seen=%0d addr=%h required 1/%h", k, ok, imem_addr, pc_m); end
         op   = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         word = {op, 12'($urandom)};
         dly  = $urandom_range(0, 3);
         for (int d = 0; d < dly; d++) begin
            halt_req = 1'($urandom); exec_done = 1'($urandom); imem_rdata = 16'($urandom);
            step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== pc_m || ir_write_en !== 1'b0)
               begin errors++; $display("FAIL rand_hold[%0d]: req=%b addr=%h we=%b required 1/%h/0", k, imem_req, imem_addr, ir_write_en, pc_m); end
         end
         xs0 = xs_cnt;
         imem_ack = 1; imem_rdata = word; step();
         imem_ack = 1'($urandom); imem_rdata = 16'($urandom); exec_done = 1'($urandom); halt_req = 1'($urandom);
         checks++;
         if (ir_write_en !== 1'b1 || ir_din !== word || opcode !== op)
            begin errors++; $display("FAIL rand_load[%0d]: we=%b ir=%h op=%h required 1/%h/%h", k, ir_write_en, ir_din, opcode, word, op); end
         if (op == 4'hF) begin
            step();
            imem_ack = 0; exec_done = 0; halt_req = 0;
            checks++;
            if (halted !== 1'b1 || pc !== pc_m || exec_start !== 1'b0 || xs_cnt != xs0)
               begin errors++; $display("FAIL rand_halt[%0d]: halted=%b pc=%h xs=%b required 1/%h/0", k, halted, pc, exec_start, pc_m); end
            start = 1; step(); start = 0;
            pc_m = 8'h00;
            continue;
         end
         step();
         checks++;
         if (exec_start !== 1'b1 || ir_write_en !== 1'b0 || ir_din !== word)
            begin errors++; $display("FAIL rand_exec[%0d]: xs=%b we=%b ir=%h required 1/0/%h", k, exec_start, ir_write_en, ir_din, word); end
         step();
         exec_done = 0; imem_ack = 1'($urandom);
         dly = $urandom_range(0, 3);
         for (int d = 0; d < dly; d++) begin
            halt_req = 1'($urandom);
            step();
            checks++;
            if (pc !== pc_m || busy !== 1'b1 || exec_start !== 1'b0 || imem_req !== 1'b0)
               begin errors++; $display("FAIL rand_wait[%0d]: pc=%h busy=%b xs=%b req=%b required %h/1/0/0", k, pc, busy, exec_start, imem_req, pc_m); end
         end
         hr = ($urandom_range(0, 3) == 0);
         br = 1'($urandom); tgt = 8'($urandom);
         exec_done = 1; branch_taken = br; branch_target = tgt; halt_req = hr; imem_ack = 0;
         step();
         exec_done = 0; branch_taken = 0; halt_req = 0;
         pc_m = br ? tgt : 8'(pc_m + 8'd1);
         checks++;
         if (pc !== pc_m || imem_req !== !hr || busy !== !hr)
            begin errors++; $display("FAIL rand_done[%0d]: pc=%h req=%b busy=%b required %h/%b/%b", k, pc, imem_req, busy, pc_m, !hr, !hr); end
         if (hr) begin
            step();
            start = 1; step(); start = 0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_wait();
      test_single();
      test_ack_delay();
      test_branch_wrap();
      test_halt();
      test_halt_req();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
